dec_gpr_mbank_ctl: RTL
======================

Name: dec_gpr_mbank_ctl

Overview:
- Parametrised successor of the single-context GPR file: multi-bank integer register file with generic port counts, register count and data width.
- Adds same-cycle write-to-read bypass, deterministic multi-port write priority, and a bank-switch sequencer that can copy the active bank into a target bank in the background.
- Sits in the decode stage. It feeds operand reads and takes writebacks from the ALU, load and divide paths. The trap/context logic drives bank switches.

Parameters:
- XLEN, 32, register data width.
- NREG, 32, registers per bank; index 0 is hardwired zero; power of two, at least 4.
- NUM_RD, 4, read port count.
- NUM_WR, 3, write port count.
- NBANK, 2, number of banks; at least 2.
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns the stored value.
- AW, $clog2(NREG), register address width (derived).
- BW, $clog2(NBANK), bank id width (derived).

Ports:
- clk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- rden  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*AW  packed read addresses; port p at [p*AW +: AW]
- rdata  out  NUM_RD*XLEN  packed read data
- wen  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*AW  packed write addresses
- wdata  in  NUM_WR*XLEN  packed write data
- sw_req  in  1  bank switch request (single-cycle pulse)
- sw_bank  in  BW  target bank
- sw_copy  in  1  1 = copy the active bank into the target before switching
- sw_busy  out  1  copy sequence in progress
- sw_done  out  1  one-cycle pulse when the switch takes effect
- bank_id  out  BW  current active bank

Behaviour:
- Reset (asynchronous, rst_l=0): every register in every bank = 0, bank_id=0, FSM=IDLE, sw_busy=0, sw_done=0. rdata is combinational and therefore 0.
- Reads:
  - Combinational, from the active bank only.
  - rdata[p] = 0 if rden[p]=0 or raddr[p]=0.
  - BYPASS=1: if any write port hits raddr[p] (non-zero) in the same cycle, rdata[p] = that write's data. Priority is as for writes.
- Writes:
  - Take effect at the clk edge into the active bank.
  - Address 0 is ignored.
  - Several ports writing the same register: the highest-index port wins. This is defined behaviour, not an error.
  - Write-enable gating: a register is clocked only when written.
- FSM states IDLE, COPY, DONE.
  - IDLE, sw_req with sw_bank==bank_id: no state change; sw_done pulses next cycle.
  - IDLE, sw_req with sw_copy=0: bank_id<=sw_bank at the next edge; sw_done=1 in that next cycle.
  - IDLE, sw_req with sw_copy=1 (and sw_bank!=bank_id): latch the target, idx<=1, go to COPY.
  - COPY: each cycle, target[idx] <= active[idx]; idx increments. After idx==NREG-1, go to DONE. COPY lasts NREG-1 cycles.
  - DONE (one cycle): bank_id<=target; sw_done=1 in the following cycle; go to IDLE.
  - sw_busy=1 in COPY and DONE.
- Writes during COPY/DONE:
  - Go to the active bank and are mirrored into the target bank.
  - If a mirrored write hits the register being copied that cycle, the write data wins over the copy data.
- sw_req while sw_busy=1 is ignored (no queueing).
- Reads during COPY/DONE return the active (old) bank.
- Reset mid-copy: the sequence aborts and bank_id returns to 0. Partially copied target contents are cleared by reset like all registers.
- Out-of-range sw_bank (>= NBANK, possible only when NBANK is not a power of two): treated as no-op. sw_done still pulses.

Decomposition:
- Package dec_gpr_pkg: state enum (IDLE, COPY, DONE) and the width helper functions for AW/BW.
- Sub-module dec_gpr_bank: one bank's storage of NREG-1 enable-gated flops.
  - Inputs: NUM_WR write ports plus one copy write port; priority merge inside, with the copy port lowest.
  - Output: the full register array.
- The top level holds the read mux, the bypass, and the FSM.

Test Plan:
- Reset, then write x5=0xDEADBEEF on port 0; next cycle read x5 on all ports -> 0xDEADBEEF. Read x0 -> 0.
- Same cycle: port0 writes x7=0x11, port2 writes x7=0x22, port1 reads x7 with BYPASS=1 -> rdata=0x22 that cycle and stored x7=0x22 after. Repeat with BYPASS=0 -> read returns the old value 0.
- Fill bank0 x1..x31 with i*3; sw_req sw_bank=1 sw_copy=1 -> sw_busy high for exactly 32 cycles (31 COPY + 1 DONE); sw_done pulses, bank_id=1; every x[i] reads i*3.
- During COPY, write x20=0xABCD at the cycle idx==20 -> after the switch x20 reads 0xABCD. Write x3 after idx has passed 3 -> also visible in the new bank.
- sw_req sw_copy=0 to bank1 -> bank_id=1 next cycle and reads return bank1 contents (0 after reset). A second sw_req during a busy copy is ignored.
- Assert rst_l=0 while idx==10 in COPY -> sw_busy=0, bank_id=0, all reads 0 after release.

Source files
------------

// File: rtl/dec_gpr_pkg.sv
// Shared types and width helpers for the multi-bank GPR file.
package dec_gpr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCopy,
        StDone
    } sw_state_e;

    function automatic int unsigned gpr_aw(input int unsigned nreg);
        return (nreg < 2) ? 1 : $clog2(nreg);
    endfunction

    function automatic int unsigned gpr_bw(input int unsigned nbank);
        return (nbank < 2) ? 1 : $clog2(nbank);
    endfunction

endpackage

// File: rtl/dec_gpr_bank.sv
// One register bank: NREG-1 enable-gated flops, x0 reads as zero.
// Write ports merge by priority: highest port index wins, copy port lowest.
module dec_gpr_bank
    import dec_gpr_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NUM_WR = 3,
    parameter int unsigned AW     = gpr_aw(NREG)
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic [NUM_WR-1:0]        i_wen,
    input  logic [NUM_WR*AW-1:0]     i_waddr,
    input  logic [NUM_WR*XLEN-1:0]   i_wdata,
    input  logic                     i_cp_we,
    input  logic [AW-1:0]            i_cp_addr,
    input  logic [XLEN-1:0]          i_cp_data,
    output logic [XLEN-1:0]          o_regs [NREG]
);

    assign o_regs[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic            w_en;
        logic [XLEN-1:0] w_d;
        logic [XLEN-1:0] r_q;

        always_comb begin
            w_en = i_cp_we && (i_cp_addr == AW'(i));
            w_d  = i_cp_data;
            for (int p = 0; p < NUM_WR; p++) begin
                if (i_wen[p] && (i_waddr[p*AW +: AW] == AW'(i))) begin
                    w_en = 1'b1;
                    w_d  = i_wdata[p*XLEN +: XLEN];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                r_q <= '0;
            end else if (w_en) begin
                r_q <= w_d;
            end
        end

        assign o_regs[i] = r_q;
    end

endmodule

// File: rtl/dec_gpr_mbank_ctl.sv
// Multi-bank GPR file: combinational read mux with optional write bypass,
// and a bank-switch sequencer that can copy the active bank into the target.
module dec_gpr_mbank_ctl
    import dec_gpr_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NUM_RD = 4,
    parameter int unsigned NUM_WR = 3,
    parameter int unsigned NBANK  = 2,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned AW     = gpr_aw(NREG),
    parameter int unsigned BW     = gpr_bw(NBANK)
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic [NUM_RD-1:0]        rden,
    input  logic [NUM_RD*AW-1:0]     raddr,
    output logic [NUM_RD*XLEN-1:0]   rdata,
    input  logic [NUM_WR-1:0]        wen,
    input  logic [NUM_WR*AW-1:0]     waddr,
    input  logic [NUM_WR*XLEN-1:0]   wdata,
    input  logic                     sw_req,
    input  logic [BW-1:0]            sw_bank,
    input  logic                     sw_copy,
    output logic                     sw_busy,
    output logic                     sw_done,
    output logic [BW-1:0]            bank_id
);

    sw_state_e       r_state;
    logic [BW-1:0]   r_bank_id;
    logic [BW-1:0]   r_target;
    logic [AW-1:0]   r_idx;
    logic            r_busy;
    logic            r_done;

    logic [XLEN-1:0] w_regs [NBANK][NREG];
    logic [XLEN-1:0] w_act  [NREG];
    logic            w_bank_ok;

    // Out-of-range targets only exist when NBANK is not a power of two.
    assign w_bank_ok = ({1'b0, sw_bank} < (BW+1)'(NBANK));

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic              w_sel;
        logic [NUM_WR-1:0] w_wen;
        logic              w_cp_we;

        // While busy, writes land in both the active and the target bank.
        assign w_sel   = (r_bank_id == BW'(b)) || (r_busy && (r_target == BW'(b)));
        assign w_wen   = w_sel ? wen : '0;
        assign w_cp_we = (r_state == StCopy) && (r_target == BW'(b));

        dec_gpr_bank #(
            .XLEN   (XLEN),
            .NREG   (NREG),
            .NUM_WR (NUM_WR),
            .AW     (AW)
        ) u_bank (
            .clk       (clk),
            .rst_l     (rst_l),
            .i_wen     (w_wen),
            .i_waddr   (waddr),
            .i_wdata   (wdata),
            .i_cp_we   (w_cp_we),
            .i_cp_addr (r_idx),
            .i_cp_data (w_act[r_idx]),
            .o_regs    (w_regs[b])
        );
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_act[i] = w_regs[r_bank_id][i];
        end
    end

    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        rdata = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra = raddr[p*AW +: AW];
            rd = '0;
            if (rden[p] && (ra != '0)) begin
                rd = w_act[ra];
                if (BYPASS != 0) begin
                    for (int q = 0; q < NUM_WR; q++) begin
                        if (wen[q] && (waddr[q*AW +: AW] == ra)) begin
                            rd = wdata[q*XLEN +: XLEN];
                        end
                    end
                end
            end
            rdata[p*XLEN +: XLEN] = rd;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state   <= StIdle;
            r_bank_id <= '0;
            r_target  <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (sw_req) begin
                        if ((sw_bank == r_bank_id) || !w_bank_ok) begin
                            r_done <= 1'b1;
                        end else if (!sw_copy) begin
                            r_bank_id <= sw_bank;
                            r_done    <= 1'b1;
                        end else begin
                            r_target <= sw_bank;
                            r_idx    <= AW'(1);
                            r_busy   <= 1'b1;
                            r_state  <= StCopy;
                        end
                    end
                end
                StCopy: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == AW'(NREG - 1)) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_bank_id <= r_target;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign sw_busy = r_busy;
    assign sw_done = r_done;
    assign bank_id = r_bank_id;

endmodule
